// File: rtl/firwin_coef_sequencer_pkg.sv
// Shared definitions for the FIR coefficient sequencer: FSM encoding,
// error flag bit positions and the generator's result width.
package firwin_coef_sequencer_pkg;

    localparam int FIRWIN_W    = 16;
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_CFG     = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_HI,
        S_WAIT_LO,
        S_SETTLE,
        S_WR_LO,
        S_WR_HI,
        S_NEXT,
        S_ERR,
        S_DONE
    } state_e;

endpackage

// File: rtl/firwin_coef_sequencer.sv
// Steps the window coefficient generator over tap indices 0..n/2 and writes
// each result to both symmetric RAM addresses i and n-i.
module firwin_coef_sequencer
    import firwin_coef_sequencer_pkg::*;
#(
    parameter int DATA_W  = FIRWIN_W,
    parameter int ADDR_W  = 10,
    parameter int EN_HOLD = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       pi_phase_in,
    input  logic [3:0]        win_type_in,
    input  logic [15:0]       n_in,
    input  logic [7:0]        lgn_in,
    output logic              gen_en,
    output logic [15:0]       gen_pi_phase,
    output logic [3:0]        gen_win_type,
    output logic [15:0]       gen_n,
    output logic [7:0]        gen_lgn,
    output logic [15:0]       gen_i,
    input  logic              gen_busy,
    input  logic [DATA_W-1:0] gen_firwin,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [DATA_W-1:0] coef_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         i_q, i_d;
    logic [15:0]         pi_q, pi_d;
    logic [3:0]          win_q, win_d;
    logic [15:0]         n_q, n_d;
    logic [7:0]          lgn_q, lgn_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          err_q, err_d;
    logic                gen_en_q, gen_en_d;
    logic                coef_we_q, coef_we_d;
    logic [ADDR_W-1:0]   coef_addr_q, coef_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [15:0] n_minus_i;
    logic        cfg_bad;
    logic        hold_last;
    logic        wait_expired;

    assign n_minus_i    = n_q - i_q;
    // Any bit at or above ADDR_W means the table cannot hold n+1 taps.
    assign cfg_bad      = |(n_in >> ADDR_W);
    assign hold_last    = (cnt_q == 16'(EN_HOLD - 1));
    assign wait_expired = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        i_d         = i_q;
        pi_d        = pi_q;
        win_d       = win_q;
        n_d         = n_q;
        lgn_d       = lgn_q;
        data_d      = data_q;
        err_d       = err_q;
        coef_addr_d = coef_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pi_d  = pi_phase_in;
                    win_d = win_type_in;
                    n_d   = n_in;
                    lgn_d = lgn_in;
                    i_d   = '0;
                    cnt_d = '0;
                    err_d = '0;
                    if (cfg_bad) begin
                        err_d[ERR_CFG] = 1'b1;
                        state_d        = S_DONE;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (hold_last) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_HI;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_HI: begin
                if (gen_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LO;
                end else if (wait_expired) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_LO: begin
                if (!gen_busy) begin
                    state_d = S_SETTLE;
                end else if (wait_expired) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                data_d      = gen_firwin;
                coef_addr_d = i_q[ADDR_W-1:0];
                state_d     = S_WR_LO;
            end
            S_WR_LO: begin
                if (i_q != n_minus_i) begin
                    coef_addr_d = n_minus_i[ADDR_W-1:0];
                    state_d     = S_WR_HI;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WR_HI: state_d = S_NEXT;
            S_NEXT: begin
                // Abort only takes effect between runs so a started run is never lost.
                if (abort || (i_q == (n_q >> 1))) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 16'd1;
                    cnt_d   = '0;
                    state_d = S_ARM;
                end
            end
            S_ERR: begin
                err_d[ERR_TIMEOUT] = 1'b1;
                state_d            = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        gen_en_d  = (state_d == S_ARM);
        coef_we_d = (state_d == S_WR_LO) || (state_d == S_WR_HI);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            i_q         <= '0;
            pi_q        <= '0;
            win_q       <= '0;
            n_q         <= '0;
            lgn_q       <= '0;
            data_q      <= '0;
            err_q       <= '0;
            gen_en_q    <= 1'b0;
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            pi_q        <= pi_d;
            win_q       <= win_d;
            n_q         <= n_d;
            lgn_q       <= lgn_d;
            data_q      <= data_d;
            err_q       <= err_d;
            gen_en_q    <= gen_en_d;
            coef_we_q   <= coef_we_d;
            coef_addr_q <= coef_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign gen_en       = gen_en_q;
    assign gen_pi_phase = pi_q;
    assign gen_win_type = win_q;
    assign gen_n        = n_q;
    assign gen_lgn      = lgn_q;
    assign gen_i        = i_q;
    assign coef_we      = coef_we_q;
    assign coef_addr    = coef_addr_q;
    assign coef_data    = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_firwin_coef_sequencer.sv
// Directed bench for the coefficient sequencer with a behavioural generator
// model and a write scoreboard of expected (addr, data) pairs.
module tb_firwin_coef_sequencer;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [15:0]       pi_phase_in = 16'h1357;
    logic [3:0]        win_type_in = 4'd3;
    logic [15:0]       n_in = '0;
    logic [7:0]        lgn_in = 8'd5;
    logic              gen_en;
    logic [15:0]       gen_pi_phase;
    logic [3:0]        gen_win_type;
    logic [15:0]       gen_n;
    logic [7:0]        gen_lgn;
    logic [15:0]       gen_i;
    logic              gen_busy = 1'b0;
    logic [DATA_W-1:0] gen_firwin = '0;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [DATA_W-1:0] coef_data;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    int  checks = 0;
    int  failures = 0;
    int  en_cnt, wr_cnt, done_cnt, gap_cnt, last_wait;
    bit  model_on = 1'b1;
    logic en_prev = 1'b0;
    wr_t sb[$];

    firwin_coef_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EN_HOLD(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pi_phase_in(pi_phase_in), .win_type_in(win_type_in), .n_in(n_in), .lgn_in(lgn_in),
        .gen_en(gen_en), .gen_pi_phase(gen_pi_phase), .gen_win_type(gen_win_type),
        .gen_n(gen_n), .gen_lgn(gen_lgn), .gen_i(gen_i),
        .gen_busy(gen_busy), .gen_firwin(gen_firwin),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fw(input logic [15:0] i, input logic [15:0] n);
        return 16'(i * 16'h0913) ^ (n << 4) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Generator model: busy rises 4 cycles after an en rising edge, lasts 14 cycles.
    initial begin
        logic [15:0] mi, mn;
        forever begin
            @(posedge gen_en);
            if (model_on) begin
                mi = gen_i;
                mn = gen_n;
                repeat (4) @(negedge clk);
                gen_firwin = fw(mi, mn);
                gen_busy   = 1'b1;
                repeat (14) @(negedge clk);
                gen_busy   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (gen_en && !en_prev) en_cnt++;
            en_prev = gen_en;
            if (done) done_cnt++;
            if (busy && !gen_en && !done) gap_cnt++;
            if (coef_we) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_write", {22'd0, coef_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", {22'd0, coef_addr}, {22'd0, e.addr});
                    check("wr_data", {16'd0, coef_data}, {16'd0, e.data});
                end
            end
        end else begin
            en_prev = 1'b0;
        end
    end

    task automatic start_run(input logic [15:0] n, input int last_i);
        for (int i = 0; i <= last_i; i++) begin
            logic [15:0] iv, hi;
            iv = 16'(i);
            hi = n - iv;
            sb.push_back('{addr: iv[ADDR_W-1:0], data: fw(iv, n)});
            if (iv != hi) sb.push_back('{addr: hi[ADDR_W-1:0], data: fw(iv, n)});
        end
        en_cnt = 0; wr_cnt = 0; done_cnt = 0; gap_cnt = 0;
        n_in  = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        last_wait = 0;
        while (!done && last_wait < limit) begin
            @(negedge clk);
            last_wait++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic finish_run(input string tag, input int exp_en, input int exp_wr, input logic [1:0] exp_err);
        wait_done(2000);
        repeat (3) @(negedge clk);
        check({tag, "_gen_en_pulses"}, 32'(en_cnt), 32'(exp_en));
        check({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_err"}, {30'd0, err}, {30'd0, exp_err});
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lim;
        repeat (3) @(negedge clk);
        check("rst_gen_en", {31'd0, gen_en}, 32'd0);
        check("rst_coef_we", {31'd0, coef_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {30'd0, err}, 32'd0);
        check("rst_gen_n", {16'd0, gen_n}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // n=4: addrs 0,4,1,3,2
        start_run(16'd4, 2);
        finish_run("n4", 3, 5, 2'b00);
        check("n4_gen_n", {16'd0, gen_n}, 32'd4);
        check("n4_gen_pi", {16'd0, gen_pi_phase}, 32'h1357);
        check("n4_gen_win", {28'd0, gen_win_type}, 32'd3);
        check("n4_gen_lgn", {24'd0, gen_lgn}, 32'd5);

        // n=5: addrs 0,5,1,4,2,3 with mirrored data
        start_run(16'd5, 2);
        finish_run("n5", 3, 6, 2'b00);

        // generator never responds: timeout
        model_on = 1'b0;
        start_run(16'd6, -1);
        finish_run("tmo", 1, 0, 2'b01);
        check("tmo_wait_cycles", 32'(gap_cnt), 32'(TIMEOUT + 1));
        model_on = 1'b1;

        // n=8 with a spurious start mid-run and abort during run 2
        start_run(16'd8, 1);
        lim = 0;
        while (!gen_busy && lim < 200) begin @(negedge clk); lim++; end
        check("abort_run1_busy", {31'd0, gen_busy}, 32'd1);
        n_in  = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lim = 0;
        while (en_cnt < 2 && lim < 200) begin @(negedge clk); lim++; end
        check("abort_run2_seen", 32'(en_cnt), 32'd2);
        abort = 1'b1;
        finish_run("abort", 2, 4, 2'b00);
        abort = 1'b0;

        // reset while waiting for busy to fall
        start_run(16'd6, -1);
        lim = 0;
        while (!gen_busy && lim < 200) begin @(negedge clk); lim++; end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_gen_en", {31'd0, gen_en}, 32'd0);
        check("rstmid_coef_we", {31'd0, coef_we}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rstmid_writes", 32'(wr_cnt), 32'd0);
        start_run(16'd3, 1);
        finish_run("post_rst", 2, 4, 2'b00);

        // n=1024 exceeds the 10-bit table
        start_run(16'd1024, -1);
        finish_run("cfg", 0, 0, 2'b10);
        check("cfg_done_latency", 32'(last_wait), 32'd0);

        // n=0: single run, single write at address 0
        start_run(16'd0, 0);
        finish_run("n0", 1, 1, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
